// File: rtl/spi_slave_sync.sv
// spi_slave_sync: mode-0 SPI slave with 2-flop synchronized inputs, oversampled by mclk
module spi_slave_sync #(
  parameter int WIDTH = 8
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             rx_full,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [WIDTH-1:0] tx_buf, tx_shift, rx_shift;
  logic [CW-1:0] bit_cnt;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_low;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_fall = ~cs_s[1] & cs_s[2];
  assign cs_rise = cs_s[1] & ~cs_s[2];
  assign cs_low = ~cs_s[1];
  assign miso = cs_low & tx_shift[WIDTH-1];
  assign data_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE  ? (cs_fall ? SHIFT : IDLE) :
              state == DONE  ? (cs_low ? SHIFT : IDLE) :
              cs_rise        ? IDLE :
              (sclk_rise && bit_cnt == LAST) ? DONE : SHIFT;
  end
  always_ff @(posedge mclk) begin
    if (reset) begin
      state <= IDLE;
      sclk_s <= 3'b000;
      cs_s <= 3'b111;
      mosi_s <= 2'b00;
      tx_buf <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      data_out <= '0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s <= {cs_s[1:0], cs};
      mosi_s <= {mosi_s[0], mosi};
      if (load) tx_buf <= data_in;
      frame_err <= state == SHIFT && cs_rise && bit_cnt != '0;
      if (rd_ack) begin
        rx_full <= 1'b0;
        overrun <= 1'b0;
      end
      // tx_shift tracks tx_buf while idle so miso never shows a stale bit at cs fall
      if (state != SHIFT) begin
        tx_shift <= tx_buf;
        bit_cnt <= '0;
      end
      if (state == DONE) begin
        data_out <= rx_shift;
        rx_full <= 1'b1;
        if (!rd_ack) overrun <= overrun | rx_full;
      end
      if (state == SHIFT && !cs_rise) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[WIDTH-2:0], mosi_s[1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        // the trailing fall of the previous frame arrives after reload; skip it
        if (sclk_fall && bit_cnt != '0) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master stimulus with hand-computed expectations
module tb_spi_slave_sync;
  logic mclk = 0, reset = 1, sclk = 0, cs = 1, mosi = 0, load = 0, rd_ack = 0;
  logic [7:0] data_in = 0;
  logic miso, data_valid, rx_full, overrun, frame_err, busy;
  logic [7:0] data_out, rx;
  int total = 0, bad = 0, dv_cnt = 0, fe_cnt = 0, dv0, fe0;
  bit seen;
  spi_slave_sync #(.WIDTH(8)) dut (
    .mclk(mclk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .data_in(data_in), .load(load), .rd_ack(rd_ack), .data_out(data_out),
    .data_valid(data_valid), .rx_full(rx_full), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );
  always #5 mclk = ~mclk;
  always @(negedge mclk) begin
    if (data_valid) dv_cnt++;
    if (frame_err) fe_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit ld, input logic [7:0] ldv, output logic [7:0] r);
    r = 0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      if (ld && i == 4) begin
        data_in = ldv;
        load = 1;
        #10 load = 0;
        #30;
      end else #40;
      sclk = 1;
      r = {r[6:0], miso};
      #40 sclk = 0;
    end
  endtask
  task automatic frame(input logic [7:0] tx, input bit ld, input logic [7:0] ldv, output logic [7:0] r);
    cs = 0;
    #80;
    xfer(tx, 8, ld, ldv, r);
    #40 cs = 1;
    #80;
  endtask
  task automatic do_load(input logic [7:0] v);
    data_in = v;
    load = 1;
    #10 load = 0;
  endtask
  task automatic ack;
    rd_ack = 1;
    #10 rd_ack = 0;
  endtask
  initial begin
    repeat (3) @(posedge mclk);
    #5 reset = 0;
    chk("rst_dout", data_out, 0);
    chk("rst_flags", {data_valid, rx_full, overrun, frame_err, busy, miso}, 0);
    // single frame
    do_load(8'h3C);
    frame(8'hA5, 0, 0, rx);
    chk("single_miso", rx, 8'h3C);
    chk("single_dout", data_out, 8'hA5);
    chk("single_dv", dv_cnt, 1);
    chk("single_full", rx_full, 1);
    chk("single_busy", busy, 0);
    // sclk toggling with cs high is ignored
    dv0 = dv_cnt;
    repeat (8) begin
      #40 sclk = 1;
      #40 sclk = 0;
    end
    #40;
    chk("cs_hi_dv", dv_cnt - dv0, 0);
    chk("cs_hi_busy", busy, 0);
    // back-to-back frames
    ack();
    chk("ack_full", rx_full, 0);
    dv0 = dv_cnt;
    cs = 0;
    #80;
    xfer(8'h01, 8, 0, 0, rx);
    chk("b2b_miso0", rx, 8'h3C);
    xfer(8'hFF, 8, 0, 0, rx);
    chk("b2b_miso1", rx, 8'h3C);
    #40 cs = 1;
    #80;
    chk("b2b_dv", dv_cnt - dv0, 2);
    chk("b2b_dout", data_out, 8'hFF);
    chk("b2b_ovr", overrun, 1);
    chk("b2b_full", rx_full, 1);
    ack();
    chk("b2b_clr", {rx_full, overrun}, 0);
    // abort after 5 bits
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    cs = 0;
    #80;
    xfer(8'h96, 5, 0, 0, rx);
    #40 cs = 1;
    #80;
    chk("abort_fe", fe_cnt - fe0, 1);
    chk("abort_dv", dv_cnt - dv0, 0);
    chk("abort_dout", data_out, 8'hFF);
    chk("abort_busy", busy, 0);
    // load during frame
    do_load(8'h11);
    frame(8'h00, 1, 8'h22, rx);
    chk("ld_f1", rx, 8'h11);
    frame(8'h00, 0, 0, rx);
    chk("ld_f2", rx, 8'h22);
    frame(8'h00, 0, 0, rx);
    chk("ld_f3", rx, 8'h22);
    chk("ld_ovr", overrun, 1);
    // reset mid-frame
    fe0 = fe_cnt;
    cs = 0;
    #80;
    xfer(8'h5A, 3, 0, 0, rx);
    reset = 1;
    #10 reset = 0;
    chk("rst_mid_dout", data_out, 0);
    chk("rst_mid_flags", {data_valid, rx_full, overrun, frame_err, busy, miso}, 0);
    cs = 1;
    #100;
    chk("rst_mid_fe", fe_cnt - fe0, 0);
    frame(8'h5A, 0, 0, rx);
    chk("post_rst_dout", data_out, 8'h5A);
    chk("post_rst_miso", rx, 8'h00);
    chk("post_rst_fe", fe_cnt - fe0, 0);
    chk("post_rst_full", {rx_full, overrun}, 2'b10);
    // rd_ack collides with DONE
    seen = 0;
    fork
      frame(8'hC3, 0, 0, rx);
      begin
        for (int k = 0; k < 300 && !seen; k++) begin
          @(negedge mclk);
          if (data_valid) begin
            seen = 1;
            rd_ack = 1;
            @(negedge mclk);
            rd_ack = 0;
          end
        end
      end
    join
    chk("col_seen", seen, 1);
    chk("col_full", rx_full, 1);
    chk("col_ovr", overrun, 0);
    chk("col_dout", data_out, 8'hC3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving frame length in bits.
REQ-002 The module SHALL have port mclk, input, 1 bit: system clock; all state SHALL update on its rising edge only.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have port sclk, input, 1 bit: SPI serial clock, asynchronous to mclk.
REQ-005 The module SHALL have port cs, input, 1 bit: SPI chip select, active low, asynchronous.
REQ-006 The module SHALL have port mosi, input, 1 bit: serial data from the master, asynchronous.
REQ-007 The module SHALL have port miso, output, 1 bit: serial data to the master.
REQ-008 The module SHALL have port data_in, input, WIDTH bits: transmit byte.
REQ-009 The module SHALL have port load, input, 1 bit: strobe that captures data_in into the transmit buffer.
REQ-010 The module SHALL have port rd_ack, input, 1 bit: consumer has read data_out.
REQ-011 The module SHALL have port data_out, output, WIDTH bits: last received frame.
REQ-012 The module SHALL have port data_valid, output, 1 bit: one-mclk pulse when a frame completes.
REQ-013 The module SHALL have port rx_full, output, 1 bit: data_out holds an unread frame.
REQ-014 The module SHALL have port overrun, output, 1 bit: sticky flag, frame completed while rx_full was 1.
REQ-015 The module SHALL have port frame_err, output, 1 bit: one-mclk pulse when cs rises mid-frame.
REQ-016 The module SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-017 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use a third registered stage.
REQ-018 The protocol SHALL be SPI mode 0, MSB first: sample mosi on the synchronized sclk rise; shift miso on the synchronized sclk fall.
REQ-019 The mclk frequency SHALL be at least 4x the sclk frequency; lower ratios are unsupported.
REQ-020 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-021 IDLE->SHIFT SHALL occur on a synchronized cs fall; on that transition tx_shift <= tx_buf, bit_cnt <= 0 and busy <= 1.
REQ-022 In SHIFT, each sclk rise SHALL shift mosi into rx_shift LSB and increment bit_cnt; each sclk fall SHALL shift tx_shift left by one, filling with 0.
REQ-023 When the rise that brings bit_cnt to WIDTH is detected, SHIFT->DONE SHALL occur.
REQ-024 In DONE, for exactly one cycle: data_out <= rx_shift, data_valid = 1, rx_full <= 1, and overrun <= 1 if rx_full was already 1; the next state SHALL be SHIFT with bit_cnt <= 0 and tx_shift <= tx_buf if cs is still low, else IDLE.
REQ-025 A synchronized cs rise while in SHIFT with bit_cnt != 0 SHALL cause: frame_err pulse for one cycle, transition to IDLE, partial data discarded, data_out unchanged.
REQ-026 A cs rise in SHIFT with bit_cnt == 0 SHALL return to IDLE with no error.
REQ-027 miso SHALL equal tx_shift[WIDTH-1] whenever synchronized cs is low, and 0 otherwise.
REQ-028 load = 1 SHALL write data_in into tx_buf in any state; a load during a frame SHALL affect only the next frame.
REQ-029 tx_buf SHALL retain its value across frames, so an un-reloaded buffer is retransmitted.
REQ-030 rd_ack = 1 SHALL clear rx_full and overrun.
REQ-031 If rd_ack and DONE occur in the same cycle, the DONE set SHALL take priority: rx_full = 1 and overrun unchanged.
REQ-032 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-033 sclk edges while cs is high SHALL be ignored.

Reset
REQ-034 reset = 1 at an mclk rise SHALL set: state = IDLE; bit_cnt, rx_shift, tx_shift, tx_buf and data_out = 0; data_valid, rx_full, overrun, frame_err, busy and miso = 0; synchronizer flops = idle levels (sclk 0, cs 1, mosi 0).
REQ-035 reset asserted mid-frame SHALL abort the frame without a frame_err pulse.
REQ-036 After reset, the first frame SHALL start only on a cs fall observed after reset release.
REQ-037 reset SHALL take priority over load and rd_ack in the same cycle.

Verification
REQ-038 Single frame: load 0x3C, master sends 0xA5 -> miso stream is 00111100; data_out = 0xA5; one data_valid pulse; rx_full = 1.
REQ-039 Back-to-back frames: 0x01 then 0xFF with cs held low and no rd_ack -> two data_valid pulses; data_out = 0xFF; overrun = 1; rd_ack then clears both flags.
REQ-040 Abort: cs rises after 5 bits of 0x96 -> frame_err pulses once; data_valid stays 0; data_out keeps its prior value; busy = 0.
REQ-041 Load during frame: tx_buf = 0x11, load 0x22 mid-frame -> current frame sends 0x11, the next frame sends 0x22; a third frame without load sends 0x22.
REQ-042 Reset mid-frame after 3 bits -> all outputs 0 the next cycle with no frame_err; a following full frame of 0x5A is received correctly.
REQ-043 Collision: rd_ack in the same cycle as DONE -> rx_full remains 1.
